alu_pipe: RTL and testbench

- Parametrised, registered successor to the 16-bit slice ALU.
- Datapath width is WIDTH bits, built from 4-bit carry-lookahead slices.
- Accepts operations over a valid/ready handshake and returns the result with flags through a one-entry output register.
- Adds NOR and a multi-cycle iterative unsigned multiply. Sits between the decode/operand stage and writeback.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_pipe_if.sv | 32 +++
 rtl/alu_cla_adder.sv | 68 ++++++
 rtl/alu_pipe.sv | 172 +++++++++++++++++
 tb/tb_alu_pipe.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM states and slice width for the pipelined ALU
package alu_pkg;

  localparam int SLICE = 4;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operation/result handshake bundle between operand stage, ALU and writeback
interface alu_pipe_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             set;
  logic             zero;
  logic             illegal;

  // Producer/consumer side: offers operations and takes results.
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, cout, overflow, set, zero, illegal
  );

  // ALU side.
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, cout, overflow, set, zero, illegal
  );

endinterface

// File: rtl/alu_cla_adder.sv
// rtl/alu_cla_adder.sv - WIDTH-bit adder from 4-bit generate/propagate slices with lookahead carries
module alu_cla_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf_raw
);

  localparam int NS = WIDTH / SLICE;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [NS-1:0]    sg;
  logic [NS-1:0]    sp;
  logic [NS:0]      sc;
  logic [WIDTH:0]   c;
  logic             term;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar s = 0; s < NS; s++) begin : g_slice
    localparam int B = s * SLICE;
    assign sp[s] = &p[B +: SLICE];
    assign sg[s] = g[B+3]
                 | (p[B+3] & g[B+2])
                 | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
  end

  // Second lookahead level: every slice carry is a flat sum of products of lower slice G/P and cin.
  always_comb begin
    sc   = '0;
    term = 1'b0;
    sc[0] = cin;
    for (int j = 1; j <= NS; j++) begin
      term = cin;
      for (int m = 0; m < j; m++) term = term & sp[m];
      sc[j] = term;
      for (int k = 0; k < j; k++) begin
        term = sg[k];
        for (int m = k + 1; m < j; m++) term = term & sp[m];
        sc[j] = sc[j] | term;
      end
    end
  end

  // Bit carries inside each slice, seeded by the lookahead slice carry at every slice boundary.
  always_comb begin
    c    = '0;
    c[0] = sc[0];
    for (int i = 0; i < WIDTH; i++) begin
      if (((i + 1) % SLICE) == 0) c[i+1] = sc[(i+1)/SLICE];
      else                        c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum     = p ^ c[WIDTH-1:0];
  assign cout    = c[WIDTH];
  assign ovf_raw = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with one-entry result slot and iterative shift-add multiply
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 cout_q, cout_d;
  logic                 ovf_q, ovf_d;
  logic                 set_q, set_d;
  logic                 zero_q, zero_d;
  logic                 illegal_q, illegal_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 in_ready;
  logic                 accept;
  logic                 sub;
  logic [WIDTH-1:0]     add_a, add_b, add_sum;
  logic                 add_cin, add_cout, add_ovf;
  logic [2*WIDTH-1:0]   acc_step;

  assign in_ready = rst_n & (state_q == IDLE) & (!out_valid_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;
  assign sub      = (bus.op == OP_SUB) || (bus.op == OP_SLT);

  // One adder serves both the single-cycle ops and the multiply accumulate step.
  always_comb begin
    add_a   = bus.a;
    add_b   = bus.b ^ {WIDTH{sub}};
    add_cin = sub;
    if (state_q == MUL) begin
      add_a   = acc_q[2*WIDTH-1:WIDTH];
      add_b   = mcand_q;
      add_cin = 1'b0;
    end
  end

  alu_cla_adder #(.WIDTH(WIDTH)) u_adder (
    .a       (add_a),
    .b       (add_b),
    .cin     (add_cin),
    .sum     (add_sum),
    .cout    (add_cout),
    .ovf_raw (add_ovf)
  );

  // Accumulator holds {partial product, remaining multiplier}; the whole pair shifts right each step.
  assign acc_step = acc_q[0] ? {add_cout, add_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};

  // Next-state and result-slot update for acceptance, retirement and multiply iteration.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    set_d       = set_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.op == OP_MUL) begin
            state_d = MUL;
            mcand_d = bus.a;
            acc_d   = {{WIDTH{1'b0}}, bus.b};
            cnt_d   = '0;
          end else begin
            out_valid_d = 1'b1;
            result_d    = '0;
            cout_d      = 1'b0;
            ovf_d       = 1'b0;
            set_d       = 1'b0;
            illegal_d   = 1'b0;
            case (bus.op)
              OP_AND: result_d = bus.a & bus.b;
              OP_OR:  result_d = bus.a | bus.b;
              OP_NOR: result_d = ~(bus.a | bus.b);
              // set mirrors the raw sum MSB for every adder op.
              OP_ADD, OP_SUB: begin
                result_d = add_sum;
                cout_d   = add_cout;
                ovf_d    = add_ovf;
                set_d    = add_sum[WIDTH-1];
              end
              OP_SLT: begin
                result_d = {{(WIDTH-1){1'b0}}, add_sum[WIDTH-1] ^ add_ovf};
                cout_d   = add_cout;
                set_d    = add_sum[WIDTH-1];
              end
              default: illegal_d = 1'b1;
            endcase
            zero_d = (result_d == '0);
          end
        end
      end
      MUL: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d     = IDLE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          result_d    = acc_step[WIDTH-1:0];
          cout_d      = |acc_step[2*WIDTH-1:WIDTH];
          ovf_d       = 1'b0;
          set_d       = 1'b0;
          illegal_d   = 1'b0;
          zero_d      = (acc_step[WIDTH-1:0] == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      set_q       <= 1'b0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      mcand_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      set_q       <= set_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.set       = set_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe at WIDTH=16 with a WIDTH=32 add regression
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct packed {
    logic [15:0] result;
    logic        cout;
    logic        ovf;
    logic        set;
    logic        zero;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [15:0] ra, rb;
  logic [3:0]  sops [6];
  int          stale;

  alu_pipe_if #(.WIDTH(16)) bus ();
  alu_pipe_if #(.WIDTH(32)) bus32 ();

  alu_pipe #(.WIDTH(16)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  alu_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    logic [16:0] s;
    logic [31:0] p;
    e = '0;
    s = '0;
    p = '0;
    case (o)
      4'b0000: e.result = x & y;
      4'b0001: e.result = x | y;
      4'b1100: e.result = ~(x | y);
      4'b0010: begin
        s = {1'b0, x} + {1'b0, y};
        e.result = s[15:0]; e.cout = s[16]; e.set = s[15];
        e.ovf = (x[15] == y[15]) && (s[15] != x[15]);
      end
      4'b0110: begin
        s = {1'b0, x} + {1'b0, ~y} + 17'd1;
        e.result = s[15:0]; e.cout = s[16]; e.set = s[15];
        e.ovf = (x[15] != y[15]) && (s[15] != x[15]);
      end
      4'b0111: begin
        s = {1'b0, x} + {1'b0, ~y} + 17'd1;
        e.result = {15'd0, ($signed(x) < $signed(y))};
        e.cout = s[16]; e.set = s[15];
      end
      4'b1000: begin
        p = 32'(x) * 32'(y);
        e.result = p[15:0];
        e.cout = |p[31:16];
      end
      default: e.illegal = 1'b1;
    endcase
    e.zero = (e.result == 16'd0);
    return e;
  endfunction

  function automatic exp_t obs();
    return {bus.result, bus.cout, bus.overflow, bus.set, bus.zero, bus.illegal};
  endfunction

  task automatic check_front(input string tag);
    exp_t e;
    chk({tag, "_valid"}, bus.out_valid, 1'b1);
    chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(tag, obs(), e);
    end
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    int n = 0;
    bus.in_valid = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", (n < 100), 1'b1);
    @(posedge clk);
    sb.push_back(model(o, x, y));
    #1;
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    bus.op = 4'($urandom);
  endtask

  task automatic wait_result(input string tag, input int exp_n);
    int   n = 0;
    logic busy_ready = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.out_valid && bus.in_ready) busy_ready = 1'b1;
    end while (!bus.out_valid && n < 100);
    chk({tag, "_latency"}, n, exp_n);
    if (exp_n > 1) chk({tag, "_in_ready_busy"}, busy_ready, 1'b0);
    check_front(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.a = '0; bus.b = '0; bus.op = '0;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b1; bus32.a = '0; bus32.b = '0; bus32.op = '0;
    sops = '{OP_AND, OP_OR, OP_NOR, OP_ADD, OP_SUB, OP_SLT};

    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs", {obs(), bus.out_valid, bus.in_ready}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_release_in_ready", bus.in_ready, 1'b1);

    issue(OP_ADD, 16'h7FFF, 16'h0001);
    wait_result("add", 1);
    chk("add_const", {bus.result, bus.overflow, bus.cout, bus.zero}, {16'h8000, 1'b1, 1'b0, 1'b0});

    issue(OP_SUB, 16'h0005, 16'h0005);
    wait_result("sub", 1);
    chk("sub_const", {bus.result, bus.zero, bus.cout, bus.overflow}, {16'h0000, 1'b1, 1'b1, 1'b0});

    issue(OP_SLT, 16'h8000, 16'h7FFF);
    wait_result("slt", 1);
    chk("slt_const", {bus.result, bus.set, bus.overflow}, {16'h0001, 1'b0, 1'b0});

    issue(OP_MUL, 16'h0100, 16'h0100);
    wait_result("mul_256", 17);
    chk("mul_256_const", {bus.result, bus.cout, bus.zero}, {16'h0000, 1'b1, 1'b1});

    issue(OP_MUL, 16'h0003, 16'h0005);
    wait_result("mul_15", 17);
    chk("mul_15_const", {bus.result, bus.cout}, {16'h000F, 1'b0});

    // Back-to-back single-cycle ops; the first acceptance also retires the multiply result.
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      bus.in_valid = 1'b1; bus.op = sops[i]; bus.a = ra; bus.b = rb;
      chk("stream_in_ready", bus.in_ready, 1'b1);
      @(posedge clk);
      sb.push_back(model(sops[i], ra, rb));
      @(negedge clk);
      check_front("stream");
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("stream_drained", bus.out_valid, 1'b0);

    // Backpressure with a queued OR waiting behind the stalled result.
    bus.out_ready = 1'b0;
    issue(OP_AND, 16'hF0F0, 16'hFF00);
    bus.in_valid = 1'b1; bus.op = OP_OR; bus.a = 16'h00F0; bus.b = 16'h0F00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_hold", obs(), sb[0]);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", bus.in_ready, 1'b1);
    check_front("bp_retire");
    @(posedge clk);
    sb.push_back(model(OP_OR, 16'h00F0, 16'h0F00));
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check_front("bp_queued");
    chk("bp_or_const", bus.result, 16'h0FF0);

    // Reset during the seventh multiply iteration.
    issue(OP_MUL, 16'h1234, 16'h0F0F);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midmul_reset", {obs(), bus.out_valid, bus.in_ready}, '0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    chk("midmul_no_stale", stale, 0);
    chk("midmul_in_ready", bus.in_ready, 1'b1);

    issue(4'b0011, 16'hABCD, 16'h1234);
    wait_result("illegal", 1);
    chk("illegal_const", {bus.result, bus.illegal, bus.zero}, {16'h0000, 1'b1, 1'b1});

    // Wide-datapath add that carries out of every slice.
    @(negedge clk);
    bus32.in_valid = 1'b1; bus32.op = OP_ADD; bus32.a = 32'hFFFF_FFFF; bus32.b = 32'h0000_0001;
    chk("w32_in_ready", bus32.in_ready, 1'b1);
    @(posedge clk);
    #1 bus32.in_valid = 1'b0;
    @(negedge clk);
    chk("w32_add", {bus32.out_valid, bus32.result, bus32.cout, bus32.zero, bus32.overflow},
        {1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
